// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and shared-ALU signals for the two-port ALU arbiter.
// The arbiter binds the slave modport; requesters and the ALU sit on the master side.
interface alu_arbiter_if #(
  parameter int SIZE = 32
);
  // Requester 0 (execute stage)
  logic            req0_valid;
  logic            req0_ready;
  logic [SIZE-1:0] req0_a;
  logic [SIZE-1:0] req0_b;
  logic [3:0]      req0_op;
  // Requester 1 (branch/address unit)
  logic            req1_valid;
  logic            req1_ready;
  logic [SIZE-1:0] req1_a;
  logic [SIZE-1:0] req1_b;
  logic [3:0]      req1_op;
  // Response channels
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [SIZE-1:0] rsp0_result;
  logic            rsp0_zero;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [SIZE-1:0] rsp1_result;
  logic            rsp1_zero;
  // Shared combinational ALU
  logic [SIZE-1:0] alu_a;
  logic [SIZE-1:0] alu_b;
  logic [3:0]      alu_op;
  logic [SIZE-1:0] alu_result;
  logic            alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero,
    input  rsp0_ready,
    output rsp1_valid, rsp1_result, rsp1_zero,
    input  rsp1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero,
    output rsp0_ready,
    input  rsp1_valid, rsp1_result, rsp1_zero,
    output rsp1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation walks IDLE -> EXEC -> RESP; the ALU is always fed from
// registered operands, and the captured result is handed back to its owner.
module alu_arbiter #(
  parameter int SIZE = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  alu_arbiter_if.slave bus,
  output logic         o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic [3:0]      r_op;
  logic [SIZE-1:0] r_result;
  logic            r_zero;
  logic            r_owner;
  logic            r_last_grant;

  logic w_idle;
  logic w_grant_any;
  logic w_grant_id;
  logic w_accept;
  logic w_rsp_done;

  assign w_idle = (r_state == S_IDLE);

  // Pick the winner: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    w_grant_any = bus.req0_valid | bus.req1_valid;
    w_grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant_id = ~r_last_grant;
    end else if (bus.req1_valid) begin
      w_grant_id = 1'b1;
    end
  end

  // READY is offered only in IDLE and never while reset is held.
  assign w_accept       = w_idle & w_grant_any & ~i_rst;
  assign bus.req0_ready = w_accept & ~w_grant_id;
  assign bus.req1_ready = w_accept &  w_grant_id;

  // The non-owner's RSP_READY is deliberately ignored.
  assign w_rsp_done = (r_state == S_RESP) & (r_owner ? bus.rsp1_ready : bus.rsp0_ready);

  // Sequence the operation and hold operands, result and arbitration history.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: every register here has a defined reset value; an abort mid-operation lands in IDLE with no result pending.
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= w_grant_id ? bus.req1_a  : bus.req0_a;
            r_b          <= w_grant_id ? bus.req1_b  : bus.req0_b;
            r_op         <= w_grant_id ? bus.req1_op : bus.req0_op;
            r_owner      <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= bus.alu_result;
          r_zero   <= bus.alu_zero;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The ALU sees only registered operands, so it holds steady outside EXEC too.
  assign bus.alu_a  = r_a;
  assign bus.alu_b  = r_b;
  assign bus.alu_op = r_op;

  // Both response buses show the captured values; only the owner's VALID rises.
  assign bus.rsp0_valid  = (r_state == S_RESP) & ~r_owner;
  assign bus.rsp1_valid  = (r_state == S_RESP) &  r_owner;
  assign bus.rsp0_result = r_result;
  assign bus.rsp1_result = r_result;
  assign bus.rsp0_zero   = r_zero;
  assign bus.rsp1_zero   = r_zero;

  assign o_busy = ~w_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU on the shared port,
// a round-robin reference model, directed scenarios and a randomized phase.
module tb_alu_arbiter;

  localparam int SIZE = 32;

  logic clk;
  logic rst;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;
  int m_last   = 1;   // reference model: requester served most recently

  alu_arbiter_if #(.SIZE(SIZE)) bus ();

  alu_arbiter #(.SIZE(SIZE)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus.slave),
    .o_busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU, also used by the model to derive expected results.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] ops [6];
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    if ($urandom_range(0, 4) == 0) return 4'($urandom);
    return ops[$urandom_range(0, 5)];
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    tick();
    tick();
    rst    = 1'b0;
    m_last = 1;
    #1;
  endtask

  // Run one transaction from IDLE: predict winner, follow it through EXEC/RESP.
  // refill: winner re-presents a fresh random op after accept; otherwise it drops VALID.
  task automatic serve(input bit refill, input int stall);
    int          w;
    logic [31:0] ea, eb, er;
    logic [3:0]  eop;
    if (bus.req0_valid && bus.req1_valid) w = 1 - m_last;
    else if (bus.req0_valid)              w = 0;
    else                                  w = 1;
    ea  = (w == 1) ? bus.req1_a  : bus.req0_a;
    eb  = (w == 1) ? bus.req1_b  : bus.req0_b;
    eop = (w == 1) ? bus.req1_op : bus.req0_op;
    er  = alu_ref(ea, eb, eop);
    #1;
    check("idle_busy",   32'(busy),           32'd0);
    check("idle_ready0", 32'(bus.req0_ready), 32'(w == 0));
    check("idle_ready1", 32'(bus.req1_ready), 32'(w == 1));
    tick();
    m_last = w;
    if (refill) set_req(w, 1'b1, $urandom, $urandom, rand_op());
    else        set_req(w, 1'b0, '0, '0, '0);
    #1;
    // EXEC
    check("exec_busy",   32'(busy),           32'd1);
    check("exec_alu_a",  bus.alu_a,           ea);
    check("exec_alu_b",  bus.alu_b,           eb);
    check("exec_alu_op", 32'(bus.alu_op),     32'(eop));
    check("exec_ready",  32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    check("exec_rspv",   32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    tick();
    // RESP: optional stall with the non-owner's READY high (must be ignored)
    for (int s = 0; s <= stall; s++) begin
      if (s < stall) begin
        if (w == 0) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
      end else begin
        bus.rsp0_ready = (w == 0);
        bus.rsp1_ready = (w == 1);
      end
      #1;
      check("resp_busy",   32'(busy),           32'd1);
      check("resp_valid0", 32'(bus.rsp0_valid), 32'(w == 0));
      check("resp_valid1", 32'(bus.rsp1_valid), 32'(w == 1));
      check("resp_result", (w == 1) ? bus.rsp1_result : bus.rsp0_result, er);
      check("resp_zero",   32'((w == 1) ? bus.rsp1_zero : bus.rsp0_zero), 32'(er == 0));
      check("resp_ready",  32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      check("resp_alu_a",  bus.alu_a, ea);
      tick();
    end
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    check("done_busy", 32'(busy), 32'd0);
    check("done_rspv", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #2;
    // Reset state
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_ready",  32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    check("rst_rspv",   32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    check("rst_alu_a",  bus.alu_a, 32'd0);
    check("rst_alu_b",  bus.alu_b, 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_result", bus.rsp0_result, 32'd0);
    check("rst_zero",   32'(bus.rsp1_zero), 32'd0);
    reset_dut();

    // Lone requester 0: 5 + 7
    set_req(0, 1'b1, 32'd5, 32'd7, 4'd2);
    serve(1'b0, 0);

    // Fresh reset, both valid with held operands: 0 first, then 1
    reset_dut();
    set_req(0, 1'b1, 32'd100, 32'd23, 4'd6);
    set_req(1, 1'b1, 32'hF0F0, 32'h0FF0, 4'd0);
    serve(1'b0, 0);
    serve(1'b0, 0);

    // Both continuously valid: six alternating grants
    set_req(0, 1'b1, $urandom, $urandom, rand_op());
    set_req(1, 1'b1, $urandom, $urandom, rand_op());
    for (int i = 0; i < 6; i++) serve(1'b1, 0);
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);

    // Requester 1: 3 - 3 gives zero
    set_req(1, 1'b1, 32'd3, 32'd3, 4'd6);
    serve(1'b0, 0);

    // Stalled response for requester 0 while requester 1 waits
    set_req(0, 1'b1, $urandom, $urandom, rand_op());
    set_req(1, 1'b1, $urandom, $urandom, rand_op());
    serve(1'b0, 5);
    serve(1'b0, 0);

    // Randomized traffic
    for (int i = 0; i < 25; i++) begin
      int vm;
      vm = $urandom_range(1, 3);
      set_req(0, vm[0], $urandom, $urandom, rand_op());
      set_req(1, vm[1], $urandom, $urandom, rand_op());
      serve(1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);

    // Reset during EXEC drops the op and restores the grant history
    set_req(0, 1'b1, 32'd9, 32'd1, 4'd2);
    #1;
    check("abort_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    #1;
    check("abort_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rspv", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("abort_hold_rspv", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    end
    rst    = 1'b0;
    m_last = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("abort_after_rspv", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    end
    set_req(0, 1'b1, $urandom, $urandom, rand_op());
    set_req(1, 1'b1, $urandom, $urandom, rand_op());
    serve(1'b0, 0);
    serve(1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
